// File: rtl/inst_fetch_unit_pkg.sv
// Shared fetch types: FSM state encoding, default read tag and the FIFO entry layout.
package fetch_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      RECV = 2'd3
   } fetch_state_e;

   localparam logic [12:0] READ_TAG_DEFAULT = 13'h1100;

   typedef struct packed {
      logic [63:0] pc;
      logic [63:0] data;
   } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_unit_fifo.sv
// Synchronous FIFO of fetch entries with flush; a push is visible at the head one cycle later.
// No internal backpressure: the owner guarantees no push when full and no pop when empty.
module fetch_fifo #(
   parameter int  DEPTH   = 16,
   parameter type entry_t = fetch_pkg::fetch_entry_t
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  entry_t                 push_dat,
   input  logic                   pop,
   input  logic                   flush,
   output entry_t                 head,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;

   entry_t        mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         count <= count + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push && !flush) mem[wr_ptr] <= push_dat;
   end

   assign head  = mem[rd_ptr];
   assign empty = (count == '0);

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch front end: tagged burst reads into a FIFO, {pc, word} to decode; head 1 cycle after a beat.
// Requests wait for a full burst of FIFO space; response beats are always acked in their own cycle.
module inst_fetch_unit
   import fetch_pkg::*;
#(
   parameter int BUS_DATA_WIDTH = 64,
   parameter int BUS_TAG_WIDTH  = 13,
   parameter int BURST_BEATS    = 8,
   parameter int FIFO_DEPTH     = 16,
   parameter logic [BUS_TAG_WIDTH-1:0] READ_TAG = BUS_TAG_WIDTH'(READ_TAG_DEFAULT)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [63:0]               entry,
   output logic                      bus_reqcyc,
   output logic [BUS_DATA_WIDTH-1:0] bus_req,
   output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
   input  logic                      bus_reqack,
   input  logic                      bus_respcyc,
   output logic                      bus_respack,
   input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
   input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
   input  logic                      redirect_valid,
   input  logic [63:0]               redirect_pc,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [BUS_DATA_WIDTH-1:0] out_data,
   output logic [63:0]               out_pc,
   output logic                      halted
);
   localparam int BYTES = BUS_DATA_WIDTH / 8;
   localparam int CW    = $clog2(FIFO_DEPTH) + 1;
   localparam int BW    = $clog2(BURST_BEATS + 1);
   localparam logic [63:0]   BEAT_STEP   = 64'(BYTES);
   localparam logic [63:0]   BURST_STEP  = 64'(BURST_BEATS * BYTES);
   localparam logic [CW-1:0] SPACE_LIMIT = CW'(FIFO_DEPTH - BURST_BEATS);
   localparam logic [BW-1:0] LAST_CNT    = BW'(BURST_BEATS - 1);

   typedef struct packed {
      logic [63:0]               pc;
      logic [BUS_DATA_WIDTH-1:0] data;
   } entry_t;

   fetch_state_e              state;
   fetch_state_e              state_nxt;
   logic [63:0]               fetch_pc;
   logic [BW-1:0]             beat_cnt;
   logic                      discard;
   logic                      req_cyc_nxt;
   logic [BUS_DATA_WIDTH-1:0] req_addr_nxt;

   logic          beat, last_beat, beat_live, zero_word, push, pop, space_ok;
   logic          fifo_empty;
   logic [CW-1:0] fifo_count;
   entry_t        push_entry, head;
   logic          unused_resptag;

   assign unused_resptag = ^bus_resptag;

   assign beat      = bus_respcyc && (state == WAIT || state == RECV) && !reset;
   assign last_beat = beat && (beat_cnt == LAST_CNT);
   // Stale (redirected) or post-halt beats are acked but never reach the FIFO.
   assign beat_live = beat && !discard && !halted && !redirect_valid;
   assign zero_word = beat_live && (bus_resp == '0);
   assign push      = beat_live && !zero_word;
   assign space_ok  = (fifo_count <= SPACE_LIMIT);

   assign push_entry.pc   = fetch_pc + BEAT_STEP * 64'(beat_cnt);
   assign push_entry.data = bus_resp;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // A redirect in IDLE holds off the request so it is issued from the new PC.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (!halted && !redirect_valid && space_ok) state_nxt = REQ;
         REQ:     if (bus_reqack) state_nxt = WAIT;
         WAIT:    if (last_beat) state_nxt = IDLE;
                  else if (beat) state_nxt = RECV;
         RECV:    if (last_beat) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus_respack  = beat;
      req_cyc_nxt  = (state_nxt == REQ);
      req_addr_nxt = '0;
      if (req_cyc_nxt) req_addr_nxt = (state == REQ) ? bus_req : BUS_DATA_WIDTH'(fetch_pc);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc   <= entry;
         beat_cnt   <= '0;
         discard    <= 1'b0;
         halted     <= 1'b0;
         bus_reqcyc <= 1'b0;
         bus_req    <= '0;
         bus_reqtag <= '0;
      end else begin
         bus_reqcyc <= req_cyc_nxt;
         bus_req    <= req_addr_nxt;
         bus_reqtag <= req_cyc_nxt ? READ_TAG : '0;
         if (zero_word) halted <= 1'b1;
         if (last_beat)  beat_cnt <= '0;
         else if (beat)  beat_cnt <= beat_cnt + BW'(1);
         if (redirect_valid)             fetch_pc <= redirect_pc;
         else if (last_beat && !discard) fetch_pc <= fetch_pc + BURST_STEP;
         if (last_beat)                              discard <= 1'b0;
         else if (redirect_valid && state != IDLE)   discard <= 1'b1;
      end
   end

   fetch_fifo #(
      .DEPTH   (FIFO_DEPTH),
      .entry_t (entry_t)
   ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (push),
      .push_dat (push_entry),
      .pop      (pop),
      .flush    (redirect_valid),
      .head     (head),
      .empty    (fifo_empty),
      .count    (fifo_count)
   );

   assign out_valid = !fifo_empty;
   assign pop       = out_valid && out_ready && !redirect_valid;
   assign out_data  = out_valid ? head.data : '0;
   assign out_pc    = out_valid ? head.pc   : '0;

endmodule

// File: tb/tb_inst_fetch_unit.sv
module tb_inst_fetch_unit;
   localparam logic [12:0] TAG = 13'h1100;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // default-geometry instance
   logic        reset, bus_reqcyc, bus_reqack, bus_respcyc, bus_respack;
   logic        redirect_valid, out_valid, out_ready, halted;
   logic [63:0] entry, bus_req, bus_resp, redirect_pc, out_data, out_pc;
   logic [12:0] bus_reqtag;

   // 32-bit, 4-beat instance
   logic        b_reset, b_reqcyc, b_reqack, b_respcyc, b_respack, b_redir, b_out_valid, b_out_ready, b_halted;
   logic [63:0] b_entry, b_redir_pc, b_out_pc;
   logic [31:0] b_req, b_resp, b_out_data;
   logic [12:0] b_reqtag;

   inst_fetch_unit dut (
      .clk(clk), .reset(reset), .entry(entry),
      .bus_reqcyc(bus_reqcyc), .bus_req(bus_req), .bus_reqtag(bus_reqtag), .bus_reqack(bus_reqack),
      .bus_respcyc(bus_respcyc), .bus_respack(bus_respack), .bus_resp(bus_resp), .bus_resptag(TAG),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_pc(out_pc), .halted(halted)
   );

   inst_fetch_unit #(.BUS_DATA_WIDTH(32), .BURST_BEATS(4), .FIFO_DEPTH(8)) dut_b (
      .clk(clk), .reset(b_reset), .entry(b_entry),
      .bus_reqcyc(b_reqcyc), .bus_req(b_req), .bus_reqtag(b_reqtag), .bus_reqack(b_reqack),
      .bus_respcyc(b_respcyc), .bus_respack(b_respack), .bus_resp(b_resp), .bus_resptag(TAG),
      .redirect_valid(b_redir), .redirect_pc(b_redir_pc),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_pc(b_out_pc), .halted(b_halted)
   );

   int errors = 0;
   int checks = 0;

   // Reference model: expected decode stream, next fetch address, halt flag.
   typedef struct { logic [63:0] pc; logic [63:0] data; } ent_t;
   ent_t        expq[$];
   logic [63:0] m_pc;
   bit          m_halted;
   bit          rnd_ready;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!reset && out_valid === 1'b1 && out_ready && !redirect_valid) begin
         if (expq.size() == 0) check("pop_without_model_entry", 64'(out_valid), 64'd0);
         else begin
            check("out_pc", out_pc, expq[0].pc);
            check("out_data", out_data, expq[0].data);
            void'(expq.pop_front());
         end
      end
   end

   task automatic step();
      @(posedge clk); #1;
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic do_burst(input int ack_dly, input int zero_at, input int redir_at,
                           input logic [63:0] rpc, input int stall, input int reset_at, input bit fixed);
      int n;
      int gaps;
      logic [63:0] base, d;
      bit disc;
      n = 0;
      while (bus_reqcyc !== 1'b1 && n < 60) begin step(); n++; end
      check("req_seen", 64'(bus_reqcyc), 64'd1);
      base = m_pc;
      check("bus_req", bus_req, base);
      check("bus_reqtag", 64'(bus_reqtag), 64'(TAG));
      for (int i = 0; i < ack_dly; i++) begin
         step();
         check("req_held", bus_req, base);
         check("reqcyc_held", 64'(bus_reqcyc), 64'd1);
      end
      bus_reqack = 1'b1;
      step();
      bus_reqack = 1'b0;
      check("reqcyc_drop", 64'(bus_reqcyc), 64'd0);
      check("req_drop", bus_req, 64'd0);
      disc = 0;
      for (int k = 0; k < 8; k++) begin
         gaps = (stall < 0) ? int'($urandom_range(0, 2)) : stall;
         for (int s = 0; s < gaps; s++) begin
            bus_respcyc = 1'b0;
            redirect_valid = 1'b0;
            @(negedge clk);
            check("respack_stall", 64'(bus_respack), 64'd0);
            step();
         end
         if (k == reset_at) begin
            reset = 1'b1;
            bus_respcyc = 1'b1;
            bus_resp = 64'hDEAD;
            @(negedge clk);
            check("respack_in_reset", 64'(bus_respack), 64'd0);
            step();
            reset = 1'b0;
            bus_respcyc = 1'b0;
            expq.delete();
            m_pc = entry;
            m_halted = 0;
            check("rst_out_valid", 64'(out_valid), 64'd0);
            check("rst_out_pc", out_pc, 64'd0);
            check("rst_out_data", out_data, 64'd0);
            check("rst_reqcyc", 64'(bus_reqcyc), 64'd0);
            check("rst_req", bus_req, 64'd0);
            check("rst_halted", 64'(halted), 64'd0);
            return;
         end
         d = fixed ? 64'h11 + 64'(k) : ({$urandom, $urandom} | 64'h1);
         if (k == zero_at) d = 64'd0;
         bus_respcyc = 1'b1;
         bus_resp = d;
         redirect_valid = (k == redir_at);
         redirect_pc = rpc;
         if (k == redir_at) begin
            expq.delete();
            m_pc = rpc;
            disc = 1;
         end else if (!disc && !m_halted) begin
            if (d == 64'd0) m_halted = 1;
            else begin
               expq.push_back('{base + 64'(k * 8), d});
               check("fifo_no_overflow", 64'(expq.size() <= 16), 64'd1);
            end
         end
         @(negedge clk);
         check("respack_beat", 64'(bus_respack), 64'd1);
         step();
         if (k == redir_at) check("flush_empty", 64'(out_valid), 64'd0);
      end
      bus_respcyc = 1'b0;
      redirect_valid = 1'b0;
      if (!disc) m_pc = base + 64'd64;
   endtask

   task automatic drain();
      int n = 0;
      rnd_ready = 0;
      out_ready = 1'b1;
      while (expq.size() != 0 && n < 200) begin step(); n++; end
      step();
      check("drain_out_valid", 64'(out_valid), 64'd0);
      check("drain_model_empty", 64'(expq.size()), 64'd0);
   endtask

   initial begin
      int n;
      reset = 1'b1; entry = 64'h1000; bus_reqack = 0; bus_respcyc = 0; bus_resp = '0;
      redirect_valid = 0; redirect_pc = '0; out_ready = 1'b1; rnd_ready = 0;
      b_reset = 1'b1; b_entry = 64'h100; b_reqack = 0; b_respcyc = 0; b_resp = '0;
      b_redir = 0; b_redir_pc = '0; b_out_ready = 0;
      m_halted = 0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_out_valid", 64'(out_valid), 64'd0);
      check("reset_reqcyc", 64'(bus_reqcyc), 64'd0);
      check("reset_req", bus_req, 64'd0);
      check("reset_reqtag", 64'(bus_reqtag), 64'd0);
      check("reset_halted", 64'(halted), 64'd0);
      check("reset_out_pc", out_pc, 64'd0);
      reset = 1'b0;
      m_pc = 64'h1000;

      // directed first burst, then a random one from 0x1040
      do_burst(2, -1, -1, 64'd0, 0, -1, 1);
      check("second_addr_model", m_pc, 64'h1040);
      do_burst(1, -1, -1, 64'd0, -1, -1, 0);
      drain();

      // backpressure: two bursts fill the FIFO, third waits for 8 pops
      out_ready = 1'b0;
      do_burst(0, -1, -1, 64'd0, -1, -1, 0);
      do_burst(0, -1, -1, 64'd0, -1, -1, 0);
      for (int i = 0; i < 20; i++) begin step(); check("no_third_req", 64'(bus_reqcyc), 64'd0); end
      out_ready = 1'b1;
      repeat (7) step();
      out_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin step(); check("no_req_after7", 64'(bus_reqcyc), 64'd0); end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      rnd_ready = 1;
      do_burst(1, -1, -1, 64'd0, -1, -1, 0);
      drain();

      // redirect during beat 3
      rnd_ready = 1;
      do_burst(0, -1, 3, 64'h2000, 0, -1, 0);
      check("redirect_target", m_pc, 64'h2000);
      do_burst(1, -1, -1, 64'd0, -1, -1, 0);
      drain();

      // 3-cycle gaps, reset mid-burst, then a burst that wraps past 2^64
      entry = 64'hFFFF_FFFF_FFFF_FFE0;
      rnd_ready = 1;
      do_burst(1, -1, -1, 64'd0, 3, 5, 0);
      do_burst(0, -1, -1, 64'd0, 3, -1, 0);
      check("wrap_next_pc", m_pc, 64'h20);
      for (int r = 0; r < 3; r++) do_burst(int'($urandom_range(0, 3)), -1, -1, 64'd0, -1, -1, 0);
      drain();

      // zero word at beat 5 halts fetch
      rnd_ready = 1;
      do_burst(0, 5, -1, 64'd0, 0, -1, 0);
      step();
      check("halted_set", 64'(halted), 64'd1);
      drain();
      for (int i = 0; i < 30; i++) begin step(); check("halt_no_req", 64'(bus_reqcyc), 64'd0); end
      redirect_valid = 1'b1; redirect_pc = 64'h5000;
      step();
      redirect_valid = 1'b0;
      for (int i = 0; i < 10; i++) begin step(); check("halt_redirect_no_req", 64'(bus_reqcyc), 64'd0); end
      check("halted_sticky", 64'(halted), 64'd1);

      // 32-bit, 4-beat geometry
      b_reset = 1'b0;
      n = 0;
      while (b_reqcyc !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
      check("b_req_seen", 64'(b_reqcyc), 64'd1);
      check("b_req_addr", 64'(b_req), 64'h100);
      check("b_reqtag", 64'(b_reqtag), 64'(TAG));
      b_reqack = 1'b1;
      @(posedge clk); #1;
      b_reqack = 1'b0;
      for (int k = 0; k < 4; k++) begin
         b_respcyc = 1'b1;
         b_resp = 32'hA1 + 32'(k);
         @(negedge clk);
         check("b_respack", 64'(b_respack), 64'd1);
         @(posedge clk); #1;
      end
      b_respcyc = 1'b0;
      n = 0;
      while (b_reqcyc !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
      check("b_second_req_addr", 64'(b_req), 64'h110);
      for (int k = 0; k < 4; k++) begin
         check("b_out_pc", b_out_pc, 64'h100 + 64'(4 * k));
         check("b_out_data", 64'(b_out_data), 64'hA1 + 64'(k));
         b_out_ready = 1'b1;
         @(posedge clk); #1;
         b_out_ready = 1'b0;
      end
      check("b_drained", 64'(b_out_valid), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
